// File: rtl/user_play_checker.sv
// Player-turn checker for the Genius game: captures button presses, compares them with the stored
// colour sequence and reports end_User / end_time / match. Optional debounce: GENIUS_DEBOUNCE_EN.
//
// state        | meaning
// IDLE         | no turn in progress, waiting for E2
// WAIT_PRESS   | expecting the colour at rd_addr, per-press timer running
// WAIT_RELEASE | correct press taken, waiting for all buttons up
// DONE         | turn finished (complete or wrong press), end_User high
// TIMEOUT      | no press in time, end_time high
module user_play_checker #(
    parameter int SEQ_MAX      = 16,
    parameter int TIMEOUT_CYC  = 50000000,
`ifdef GENIUS_DEBOUNCE_EN
    parameter int DEBOUNCE_CYC = 250000,
`endif
    localparam int IDX_W = $clog2(SEQ_MAX),
    localparam int TMR_W = $clog2(TIMEOUT_CYC + 1)
) (
    input  logic             CLOCK,
    input  logic             reset,
    input  logic             R1,
    input  logic             E2,
    input  logic [3:0]       btn,
    input  logic [IDX_W:0]   round_len,
    input  logic [1:0]       seq_color,
    output logic [IDX_W-1:0] rd_addr,
    output logic [1:0]       user_color,
    output logic             user_valid,
    output logic             end_User,
    output logic             end_time,
    output logic             match
);

    typedef enum logic [2:0] {
        IDLE         = 3'd0,
        WAIT_PRESS   = 3'd1,
        WAIT_RELEASE = 3'd2,
        DONE         = 3'd3,
        TIMEOUT      = 3'd4
    } state_t;

    state_t           state, state_nxt;
    logic [3:0]       bsync_1, bsync, bin;
    logic [IDX_W-1:0] idx, idx_nxt;
    logic [TMR_W-1:0] timer, timer_nxt;
    logic [1:0]       user_color_nxt;
    logic             user_valid_nxt, match_nxt;
    logic [IDX_W:0]   len_eff;
    logic             pressed, one_hot, hit, last, expiring;
    logic [1:0]       press_color;

    always_ff @(posedge CLOCK or posedge reset) begin
        if (reset) begin
            bsync_1 <= '0;
            bsync   <= '0;
        end else if (R1) begin
            bsync_1 <= '0;
            bsync   <= '0;
        end else begin
            bsync_1 <= btn;
            bsync   <= bsync_1;
        end
    end

`ifdef GENIUS_DEBOUNCE_EN
    localparam int DEB_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;

    logic [DEB_W-1:0] deb_cnt;
    logic [3:0]       deb;

    // bsync_1 != bsync means bsync changes on this edge, so the stability count restarts.
    always_ff @(posedge CLOCK or posedge reset) begin
        if (reset) begin
            deb_cnt <= '0;
            deb     <= '0;
        end else if (R1) begin
            deb_cnt <= '0;
            deb     <= '0;
        end else if (bsync_1 != bsync) begin
            deb_cnt <= '0;
        end else if (deb_cnt == DEB_W'(DEBOUNCE_CYC - 1)) begin
            deb <= bsync;
        end else begin
            deb_cnt <= deb_cnt + DEB_W'(1);
        end
    end

    assign bin = deb;
`else
    assign bin = bsync;
`endif

    assign len_eff  = (round_len > (IDX_W+1)'(SEQ_MAX)) ? (IDX_W+1)'(SEQ_MAX) : round_len;
    assign pressed  = |bin;
    assign one_hot  = $onehot(bin);
    assign hit      = (press_color == seq_color);
    assign last     = ({1'b0, idx} >= len_eff - (IDX_W+1)'(1)) || (idx == IDX_W'(SEQ_MAX - 1));
    assign expiring = (timer <= TMR_W'(1));
    assign rd_addr  = idx;

    always_comb begin
        press_color = 2'd0;
        case (bin)
            4'b0010: press_color = 2'd1;
            4'b0100: press_color = 2'd2;
            4'b1000: press_color = 2'd3;
            default: press_color = 2'd0;
        endcase
    end

    always_ff @(posedge CLOCK or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            idx        <= '0;
            timer      <= '0;
            user_color <= '0;
            user_valid <= 1'b0;
            match      <= 1'b0;
            end_User   <= 1'b0;
            end_time   <= 1'b0;
        end else if (R1) begin
            state      <= IDLE;
            idx        <= '0;
            timer      <= '0;
            user_color <= '0;
            user_valid <= 1'b0;
            match      <= 1'b0;
            end_User   <= 1'b0;
            end_time   <= 1'b0;
        end else begin
            state      <= state_nxt;
            idx        <= idx_nxt;
            timer      <= timer_nxt;
            user_color <= user_color_nxt;
            user_valid <= user_valid_nxt;
            match      <= match_nxt;
            end_User   <= (state_nxt == DONE);
            end_time   <= (state_nxt == TIMEOUT);
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (E2) state_nxt = (len_eff == '0) ? DONE : WAIT_PRESS;
            end
            WAIT_PRESS: begin
                if (!E2)                         state_nxt = IDLE;
                else if (pressed) begin
                    if (!one_hot || !hit || last) state_nxt = DONE;
                    else                          state_nxt = WAIT_RELEASE;
                end else if (expiring)           state_nxt = TIMEOUT;
            end
            WAIT_RELEASE: begin
                if (!E2)           state_nxt = IDLE;
                else if (!pressed) state_nxt = WAIT_PRESS;
                else if (expiring) state_nxt = TIMEOUT;
            end
            DONE, TIMEOUT: begin
                if (!E2) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // The press check runs before the timer check so a press on the expiring edge still counts.
    always_comb begin
        idx_nxt        = idx;
        timer_nxt      = timer;
        match_nxt      = match;
        user_valid_nxt = 1'b0;
        user_color_nxt = user_color;
        case (state)
            IDLE: begin
                if (E2) begin
                    idx_nxt   = '0;
                    timer_nxt = TMR_W'(TIMEOUT_CYC);
                    match_nxt = 1'b1;
                end
            end
            WAIT_PRESS: begin
                if (!E2) begin
                    match_nxt = 1'b0;
                end else if (pressed) begin
                    if (one_hot) begin
                        user_valid_nxt = 1'b1;
                        user_color_nxt = press_color;
                        if (!hit) begin
                            match_nxt = 1'b0;
                        end else if (!last) begin
                            idx_nxt   = idx + IDX_W'(1);
                            timer_nxt = TMR_W'(TIMEOUT_CYC);
                        end
                    end else begin
                        match_nxt = 1'b0;
                    end
                end else begin
                    timer_nxt = (timer != '0) ? timer - TMR_W'(1) : '0;
                    if (expiring) match_nxt = 1'b0;
                end
            end
            WAIT_RELEASE: begin
                if (!E2) begin
                    match_nxt = 1'b0;
                end else begin
                    timer_nxt = (timer != '0) ? timer - TMR_W'(1) : '0;
                    if (pressed && expiring) match_nxt = 1'b0;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_user_play_checker.sv
// Bench for user_play_checker: scoreboard of expected user_valid colours plus per-scenario checks
// of end_User / end_time / match / rd_addr. Build with GENIUS_DEBOUNCE_EN for the debounce scenario.
module tb_user_play_checker;

`ifdef GENIUS_DEBOUNCE_EN
    localparam int DEB  = 8;
    localparam int TO   = 60;
    localparam int LAT  = DEB + 2;
    localparam int HOLD = DEB + 4;
`else
    localparam int TO   = 10;
    localparam int LAT  = 2;
    localparam int HOLD = 3;
`endif

    logic       CLOCK = 1'b0;
    logic       reset, R1, E2;
    logic [3:0] btn;
    logic [4:0] round_len;
    logic [1:0] seq_color;
    logic [3:0] rd_addr;
    logic [1:0] user_color;
    logic       user_valid, end_User, end_time, match;

    logic [1:0] seq_mem [16];
    logic [1:0] exp_q [$];
    logic [1:0] mon_exp;
    int vectors = 0;
    int miscompares = 0;

    user_play_checker #(
        .SEQ_MAX(16),
`ifdef GENIUS_DEBOUNCE_EN
        .DEBOUNCE_CYC(DEB),
`endif
        .TIMEOUT_CYC(TO)
    ) dut (
        .CLOCK(CLOCK), .reset(reset), .R1(R1), .E2(E2), .btn(btn),
        .round_len(round_len), .seq_color(seq_color), .rd_addr(rd_addr),
        .user_color(user_color), .user_valid(user_valid), .end_User(end_User),
        .end_time(end_time), .match(match)
    );

    assign seq_color = seq_mem[rd_addr];

    always #5 CLOCK = ~CLOCK;

    always @(negedge CLOCK) begin
        if (!reset && user_valid === 1'b1) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL user_valid_unexpected: got pulse with colour %0d, required no pulse", user_color);
            end else begin
                mon_exp = exp_q.pop_front();
                if (user_color !== mon_exp) begin
                    miscompares++;
                    $display("FAIL user_color: got %0d, required %0d", user_color, mon_exp);
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic wait_evt(input int sel, input int bound, output int n);
        logic seen;
        seen = 1'b0;
        n = 0;
        while (!seen && n < bound) begin
            @(posedge CLOCK);
            n++;
            @(negedge CLOCK);
            case (sel)
                0:       seen = (end_User === 1'b1);
                1:       seen = (end_time === 1'b1);
                default: seen = (user_valid === 1'b1);
            endcase
        end
        if (!seen) n = -1;
    endtask

    task automatic press(input logic [3:0] m, input bit expect_pulse, input logic [1:0] c);
        if (expect_pulse) exp_q.push_back(c);
        btn = m;
        repeat (HOLD) @(negedge CLOCK);
        btn = 4'b0000;
        repeat (HOLD) @(negedge CLOCK);
    endtask

    task automatic clear_all();
        E2 = 1'b0;
        btn = 4'b0000;
        R1 = 1'b1;
        @(negedge CLOCK);
        R1 = 1'b0;
        @(negedge CLOCK);
    endtask

    task automatic start_turn(input logic [4:0] len);
        round_len = len;
        E2 = 1'b1;
        @(negedge CLOCK);
    endtask

    task automatic check_drained(input string name);
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL %s_missing_pulses: %0d expected user_valid pulses not seen, required 0", name, exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic test_reset();
        reset = 1'b1; R1 = 1'b0; E2 = 1'b0; btn = 4'b0000; round_len = 5'd0;
        repeat (2) @(negedge CLOCK);
        vectors++;
        if ({user_valid, end_User, end_time, match} !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_flags: got uv/eu/et/m=%b, required 0000", {user_valid, end_User, end_time, match});
        end
        vectors++;
        if (rd_addr !== 4'd0 || user_color !== 2'd0) begin
            miscompares++;
            $display("FAIL reset_addr_color: got rd_addr=%0d colour=%0d, required 0/0", rd_addr, user_color);
        end
        reset = 1'b0;
        @(negedge CLOCK);
    endtask

    task automatic test_sequence();
        int n;
        clear_all();
        seq_mem[0] = 2'd2; seq_mem[1] = 2'd0; seq_mem[2] = 2'd3;
        start_turn(5'd3);
        press(4'b0100, 1, 2'd2);
        press(4'b0001, 1, 2'd0);
        exp_q.push_back(2'd3);
        btn = 4'b1000;
        wait_evt(0, LAT + 30, n);
        vectors++;
        if (n != LAT + 1) begin
            miscompares++;
            $display("FAIL seq_end_latency: got end_User after %0d edges, required %0d", n, LAT + 1);
        end
        vectors++;
        if (match !== 1'b1) begin
            miscompares++;
            $display("FAIL seq_match: got %b, required 1", match);
        end
        btn = 4'b0000;
        repeat (HOLD) @(negedge CLOCK);
        check_drained("seq");
        E2 = 1'b0;
        repeat (2) @(negedge CLOCK);
        vectors++;
        if (end_User !== 1'b0 || match !== 1'b1) begin
            miscompares++;
            $display("FAIL seq_after_e2: got end_User=%b match=%b, required 0/1", end_User, match);
        end
    endtask

    task automatic test_wrong_press();
        int n;
        clear_all();
        start_turn(5'd3);
        press(4'b0100, 1, 2'd2);
        exp_q.push_back(2'd1);
        btn = 4'b0010;
        wait_evt(0, LAT + 30, n);
        vectors++;
        if (n != LAT + 1 || match !== 1'b0) begin
            miscompares++;
            $display("FAIL wrong_end: got edges=%0d match=%b, required %0d/0", n, match, LAT + 1);
        end
        vectors++;
        if (rd_addr !== 4'd1) begin
            miscompares++;
            $display("FAIL wrong_rd_addr: got %0d, required 1", rd_addr);
        end
        btn = 4'b0000;
        repeat (HOLD) @(negedge CLOCK);
        check_drained("wrong");
    endtask

    task automatic test_timeout();
        int n;
        clear_all();
        round_len = 5'd3;
        E2 = 1'b1;
        wait_evt(1, TO + 30, n);
        vectors++;
        if (n != TO + 1) begin
            miscompares++;
            $display("FAIL timeout_latency: got end_time after %0d edges, required %0d", n, TO + 1);
        end
        vectors++;
        if (match !== 1'b0 || end_User !== 1'b0) begin
            miscompares++;
            $display("FAIL timeout_flags: got match=%b end_User=%b, required 0/0", match, end_User);
        end
        E2 = 1'b0;
        repeat (2) @(negedge CLOCK);
        vectors++;
        if (end_time !== 1'b0) begin
            miscompares++;
            $display("FAIL timeout_clear: got end_time=%b, required 0", end_time);
        end
    endtask

    task automatic test_multi_press();
        int n;
        clear_all();
        start_turn(5'd3);
        btn = 4'b0101;
        wait_evt(0, LAT + 30, n);
        vectors++;
        if (n != LAT + 1 || match !== 1'b0) begin
            miscompares++;
            $display("FAIL multi_end: got edges=%0d match=%b, required %0d/0", n, match, LAT + 1);
        end
        btn = 4'b0000;
        repeat (HOLD) @(negedge CLOCK);
        check_drained("multi");
    endtask

    task automatic test_abort();
        clear_all();
        start_turn(5'd3);
        press(4'b0100, 1, 2'd2);
        E2 = 1'b0;
        repeat (2) @(negedge CLOCK);
        vectors++;
        if ({match, end_User, end_time} !== 3'b000) begin
            miscompares++;
            $display("FAIL abort_flags: got m/eu/et=%b, required 000", {match, end_User, end_time});
        end
        check_drained("abort");
    endtask

    task automatic test_len_zero_and_r1();
        clear_all();
        start_turn(5'd0);
        vectors++;
        if (end_User !== 1'b1 || match !== 1'b1) begin
            miscompares++;
            $display("FAIL len0: got end_User=%b match=%b, required 1/1", end_User, match);
        end
        E2 = 1'b0;
        repeat (2) @(negedge CLOCK);
        R1 = 1'b1;
        @(negedge CLOCK);
        R1 = 1'b0;
        vectors++;
        if (match !== 1'b0 || end_User !== 1'b0) begin
            miscompares++;
            $display("FAIL r1_clear: got match=%b end_User=%b, required 0/0", match, end_User);
        end
    endtask

    task automatic test_len_clamp();
        int n;
        clear_all();
        for (int i = 0; i < 16; i++) seq_mem[i] = 2'(i % 4);
        start_turn(5'd31);
        for (int i = 0; i < 15; i++) press(4'b0001 << (i % 4), 1, 2'(i % 4));
        vectors++;
        if (rd_addr !== 4'd15 || end_User !== 1'b0) begin
            miscompares++;
            $display("FAIL clamp_mid: got rd_addr=%0d end_User=%b, required 15/0", rd_addr, end_User);
        end
        exp_q.push_back(2'd3);
        btn = 4'b1000;
        wait_evt(0, LAT + 30, n);
        vectors++;
        if (n != LAT + 1 || match !== 1'b1 || rd_addr !== 4'd15) begin
            miscompares++;
            $display("FAIL clamp_end: got edges=%0d match=%b rd_addr=%0d, required %0d/1/15", n, match, rd_addr, LAT + 1);
        end
        btn = 4'b0000;
        repeat (HOLD) @(negedge CLOCK);
        check_drained("clamp");
    endtask

    task automatic test_reset_mid_turn();
        clear_all();
        seq_mem[0] = 2'd2; seq_mem[1] = 2'd0; seq_mem[2] = 2'd3;
        start_turn(5'd3);
        press(4'b0100, 1, 2'd2);
        press(4'b0001, 1, 2'd0);
        vectors++;
        if (rd_addr !== 4'd2 || match !== 1'b1) begin
            miscompares++;
            $display("FAIL midreset_pre: got rd_addr=%0d match=%b, required 2/1", rd_addr, match);
        end
        #2;
        reset = 1'b1;
        #1;
        vectors++;
        if (rd_addr !== 4'd0 || {user_valid, end_User, end_time, match} !== 4'b0000 || user_color !== 2'd0) begin
            miscompares++;
            $display("FAIL midreset_async: got rd_addr=%0d uv/eu/et/m=%b colour=%0d, required 0/0000/0",
                     rd_addr, {user_valid, end_User, end_time, match}, user_color);
        end
        E2 = 1'b0;
        @(negedge CLOCK);
        reset = 1'b0;
        @(negedge CLOCK);
        check_drained("midreset");
    endtask

`ifdef GENIUS_DEBOUNCE_EN
    task automatic test_debounce();
        int n;
        clear_all();
        seq_mem[0] = 2'd1;
        start_turn(5'd1);
        btn = 4'b0010;
        repeat (5) @(negedge CLOCK);
        btn = 4'b0000;
        repeat (DEB + 6) @(negedge CLOCK);
        vectors++;
        if (end_User !== 1'b0 || rd_addr !== 4'd0) begin
            miscompares++;
            $display("FAIL deb_glitch: got end_User=%b rd_addr=%0d, required 0/0", end_User, rd_addr);
        end
        exp_q.push_back(2'd1);
        btn = 4'b0010;
        wait_evt(2, LAT + 30, n);
        vectors++;
        if (n != LAT + 1) begin
            miscompares++;
            $display("FAIL deb_latency: got user_valid after %0d edges, required %0d", n, LAT + 1);
        end
        repeat (2) @(negedge CLOCK);
        btn = 4'b0000;
        vectors++;
        if (end_User !== 1'b1 || match !== 1'b1) begin
            miscompares++;
            $display("FAIL deb_end: got end_User=%b match=%b, required 1/1", end_User, match);
        end
        repeat (HOLD) @(negedge CLOCK);
        check_drained("deb");
    endtask
`endif

    initial begin
        for (int i = 0; i < 16; i++) seq_mem[i] = 2'd0;
        test_reset();
        test_sequence();
        test_wrong_press();
        test_timeout();
        test_multi_press();
        test_abort();
        test_len_zero_and_r1();
        test_len_clamp();
        test_reset_mid_turn();
`ifdef GENIUS_DEBOUNCE_EN
        test_debounce();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
